// File: rtl/mc_pkg.sv
// Shared types for the data-RAM port arbiter: FSM states, access direction and grant owner.
package mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } mc_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } mc_owner_e;

  localparam logic MC_RW_READ  = 1'b0;
  localparam logic MC_RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes and RAM control strobes of the data-RAM port arbiter.
// The bidirectional RAM data bus stays a plain port on the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  logic              if_mc_en;
  logic [ADDR_W-1:0] if_mc_addr;
  logic [DATA_W-1:0] mc_if_data;
  logic              mc_if_valid;
  logic              mem_mc_en;
  logic              mem_mc_rw;
  logic [ADDR_W-1:0] mem_mc_addr;
  logic [DATA_W-1:0] mem_mc_data;
  logic [DATA_W-1:0] mc_mem_data;
  logic              mc_mem_valid;
  logic [ADDR_W-1:0] mc_ram_addr;
  logic              mc_ram_wre;
  logic              mc_ram_oe;

  modport slave (
    input  if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_data,
    output mc_if_data, mc_if_valid, mc_mem_data, mc_mem_valid,
    output mc_ram_addr, mc_ram_wre, mc_ram_oe
  );

  modport master (
    output if_mc_en, if_mc_addr, mem_mc_en, mem_mc_rw, mem_mc_addr, mem_mc_data,
    input  mc_if_data, mc_if_valid, mc_mem_data, mc_mem_valid,
    input  mc_ram_addr, mc_ram_wre, mc_ram_oe
  );

endinterface

// File: rtl/mc_grant_sel.sv
// Grant choice between fetch and memory stage, with the counter that bounds
// how many memory-stage grants may overtake a waiting fetch.
module mc_grant_sel
  import mc_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      in_idle_i,
  input  logic      if_en_i,
  input  logic      mem_en_i,
  output logic      grant_o,
  output mc_owner_e owner_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       memWins;

  // MEM can only win over a waiting fetch while below the limit, so the
  // increment saturates at LIMIT without an explicit clamp.
  always_comb begin
    memWins  = mem_en_i && (!if_en_i || (starve_q < LIMIT));
    grant_o  = in_idle_i && (mem_en_i || if_en_i);
    owner_o  = memWins ? OWN_MEM : OWN_IF;
    starve_d = starve_q;
    if (in_idle_i) begin
      starve_d = (memWins && if_en_i) ? starve_q + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data RAM arbiter: serialises fetch reads and memory-stage reads/writes,
// owns the RAM data bus and strobes, and returns data with a one-cycle valid pulse.
module mem_port_arbiter
  import mc_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave mc,
  inout  wire  [DATA_W-1:0] mc_ram_data
);

  mc_state_e         state_q;
  mc_owner_e         owner_q;
  mc_owner_e         grantOwner;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ifData_q;
  logic [DATA_W-1:0] memData_q;
  logic              ifValid_q;
  logic              memValid_q;
  logic              wre_q;
  logic              oe_q;

  mc_grant_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_sel (
    .clock     (clock),
    .reset     (reset),
    .in_idle_i (state_q == IDLE),
    .if_en_i   (mc.if_mc_en),
    .mem_en_i  (mc.mem_mc_en),
    .grant_o   (grant),
    .owner_o   (grantOwner)
  );

  // Strobes and valids are set on the edge that enters their state, so every
  // RAM-facing output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      ifData_q   <= '0;
      memData_q  <= '0;
      ifValid_q  <= 1'b0;
      memValid_q <= 1'b0;
      wre_q      <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      ifValid_q  <= 1'b0;
      memValid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q <= grantOwner;
            if (grantOwner == OWN_MEM) begin
              addr_q  <= mc.mem_mc_addr;
              wdata_q <= mc.mem_mc_data;
            end else begin
              addr_q <= mc.if_mc_addr;
            end
            if ((grantOwner == OWN_MEM) && (mc.mem_mc_rw == MC_RW_WRITE)) begin
              state_q <= WR;
              wre_q   <= 1'b1;
            end else begin
              state_q <= RD;
              oe_q    <= 1'b1;
            end
          end
        end
        RD: begin
          oe_q    <= 1'b0;
          state_q <= DONE;
          if (owner_q == OWN_MEM) begin
            memData_q  <= mc_ram_data;
            memValid_q <= 1'b1;
          end else begin
            ifData_q  <= mc_ram_data;
            ifValid_q <= 1'b1;
          end
        end
        WR: begin
          wre_q      <= 1'b0;
          memValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The write strobe is high exactly in WR, which is the only cycle the bus is ours.
  assign mc_ram_data     = wre_q ? wdata_q : {DATA_W{1'bz}};
  assign mc.mc_ram_addr  = addr_q;
  assign mc.mc_ram_wre   = wre_q;
  assign mc.mc_ram_oe    = oe_q;
  assign mc.mc_if_data   = ifData_q;
  assign mc.mc_if_valid  = ifValid_q;
  assign mc.mc_mem_data  = memData_q;
  assign mc.mc_mem_valid = memValid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic compared
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  import mc_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  logic clock = 1'b0;
  logic reset;
  logic preloadEn;
  logic [ADDR_W-1:0] preloadAddr;
  logic [DATA_W-1:0] preloadData;
  logic [DATA_W-1:0] ram [0:65535];
  wire  [DATA_W-1:0] ramBus;
  int checks = 0;
  int failures = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) arb ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mc          (arb),
    .mc_ram_data (ramBus)
  );

  always #5 clock = ~clock;

  // Asynchronous-read RAM that drives the bus only while output-enabled.
  assign ramBus = arb.mc_ram_oe ? ram[arb.mc_ram_addr] : {DATA_W{1'bz}};

  always @(posedge clock) begin
    if (arb.mc_ram_wre) ram[arb.mc_ram_addr] <= ramBus;
    else if (preloadEn) ram[preloadAddr] <= preloadData;
  end

  function automatic bit busIdle();
    return (ramBus === {DATA_W{1'bz}}) || (ramBus === {DATA_W{1'b0}});
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    preloadAddr = a;
    preloadData = d;
    preloadEn = 1'b1;
    @(negedge clock);
    preloadEn = 1'b0;
  endtask

  task automatic doReset();
    arb.if_mc_en = 1'b0;
    arb.if_mc_addr = '0;
    arb.mem_mc_en = 1'b0;
    arb.mem_mc_rw = MC_RW_READ;
    arb.mem_mc_addr = '0;
    arb.mem_mc_data = '0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (arb.mc_ram_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_oe: got %b want 0", arb.mc_ram_oe); end
    checks++; if (arb.mc_ram_wre !== 1'b0) begin failures++; $display("[TB] FAIL reset_wre: got %b want 0", arb.mc_ram_wre); end
    checks++; if (arb.mc_ram_addr !== 16'h0000) begin failures++; $display("[TB] FAIL reset_addr: got %h want 0000", arb.mc_ram_addr); end
    checks++; if ({arb.mc_if_valid, arb.mc_mem_valid} !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid: got %b%b want 00", arb.mc_if_valid, arb.mc_mem_valid); end
    checks++; if (arb.mc_if_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_if_data: got %h want 0", arb.mc_if_data); end
    checks++; if (arb.mc_mem_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_data: got %h want 0", arb.mc_mem_data); end
    checks++; if (!busIdle()) begin failures++; $display("[TB] FAIL reset_bus: got %h want high-Z", ramBus); end
  endtask

  task automatic test_if_read();
    doReset();
    preload(16'h0010, 32'hDEADBEEF);
    arb.if_mc_addr = 16'h0010;
    arb.if_mc_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      checks++; if (arb.mc_ram_oe !== (j == 0)) begin failures++; $display("[TB] FAIL ifrd_oe[%0d]: got %b want %b", j, arb.mc_ram_oe, j == 0); end
      checks++; if (arb.mc_if_valid !== (j == 1)) begin failures++; $display("[TB] FAIL ifrd_valid[%0d]: got %b want %b", j, arb.mc_if_valid, j == 1); end
      checks++; if (arb.mc_mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL ifrd_memvalid[%0d]: got %b want 0", j, arb.mc_mem_valid); end
      if (j == 0) begin
        checks++; if (arb.mc_ram_addr !== 16'h0010) begin failures++; $display("[TB] FAIL ifrd_addr: got %h want 0010", arb.mc_ram_addr); end
      end
      if (j == 1) begin
        checks++; if (arb.mc_if_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL ifrd_data: got %h want deadbeef", arb.mc_if_data); end
        arb.if_mc_en = 1'b0;
      end
    end
  endtask

  task automatic test_mem_write_read();
    doReset();
    arb.mem_mc_addr = 16'h0020;
    arb.mem_mc_data = 32'h12345678;
    arb.mem_mc_rw = MC_RW_WRITE;
    arb.mem_mc_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      checks++; if (arb.mc_ram_wre !== (j == 0)) begin failures++; $display("[TB] FAIL memwr_wre[%0d]: got %b want %b", j, arb.mc_ram_wre, j == 0); end
      checks++; if (arb.mc_ram_oe !== 1'b0) begin failures++; $display("[TB] FAIL memwr_oe[%0d]: got %b want 0", j, arb.mc_ram_oe); end
      checks++; if (arb.mc_mem_valid !== (j == 1)) begin failures++; $display("[TB] FAIL memwr_valid[%0d]: got %b want %b", j, arb.mc_mem_valid, j == 1); end
      if (j == 0) begin
        checks++; if (ramBus !== 32'h12345678) begin failures++; $display("[TB] FAIL memwr_bus: got %h want 12345678", ramBus); end
      end else begin
        checks++; if (!busIdle()) begin failures++; $display("[TB] FAIL memwr_bus_idle[%0d]: got %h want high-Z", j, ramBus); end
      end
      if (j == 1) begin
        checks++; if (arb.mc_mem_data !== 32'h0) begin failures++; $display("[TB] FAIL memwr_data_held: got %h want 0", arb.mc_mem_data); end
        arb.mem_mc_en = 1'b0;
      end
    end
    arb.mem_mc_rw = MC_RW_READ;
    arb.mem_mc_data = 32'hFFFF0000;
    arb.mem_mc_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      checks++; if (arb.mc_ram_oe !== (j == 0)) begin failures++; $display("[TB] FAIL memrd_oe[%0d]: got %b want %b", j, arb.mc_ram_oe, j == 0); end
      checks++; if (arb.mc_mem_valid !== (j == 1)) begin failures++; $display("[TB] FAIL memrd_valid[%0d]: got %b want %b", j, arb.mc_mem_valid, j == 1); end
      checks++; if (arb.mc_if_valid !== 1'b0) begin failures++; $display("[TB] FAIL memrd_ifvalid[%0d]: got %b want 0", j, arb.mc_if_valid); end
      if (j == 1) begin
        checks++; if (arb.mc_mem_data !== 32'h12345678) begin failures++; $display("[TB] FAIL memrd_data: got %h want 12345678", arb.mc_mem_data); end
        arb.mem_mc_en = 1'b0;
      end
    end
  endtask

  task automatic test_starvation();
    doReset();
    preload(16'h0040, 32'h11110000);
    preload(16'h0050, 32'h22220000);
    arb.mem_mc_rw = MC_RW_READ;
    arb.mem_mc_addr = 16'h0040;
    arb.if_mc_addr = 16'h0050;
    arb.mem_mc_en = 1'b1;
    arb.if_mc_en = 1'b1;
    for (int n = 0; n < 15; n++) begin
      bit gotValid;
      bit expIf;
      int waitCyc;
      gotValid = 1'b0;
      waitCyc = 0;
      expIf = ((n % (LIMIT + 1)) == LIMIT);
      while (!gotValid && waitCyc < 8) begin
        @(negedge clock);
        waitCyc++;
        gotValid = arb.mc_if_valid || arb.mc_mem_valid;
      end
      checks++;
      if (!gotValid) begin
        failures++; $display("[TB] FAIL starve_timeout[%0d]: got no valid within 8 cycles want one", n);
      end else begin
        if ({arb.mc_if_valid, arb.mc_mem_valid} !== {expIf, !expIf}) begin
          failures++; $display("[TB] FAIL starve_grant[%0d]: got if=%b mem=%b want if=%b mem=%b", n, arb.mc_if_valid, arb.mc_mem_valid, expIf, !expIf);
        end
        checks++;
        if (expIf && arb.mc_if_data !== 32'h22220000) begin
          failures++; $display("[TB] FAIL starve_ifdata[%0d]: got %h want 22220000", n, arb.mc_if_data);
        end else if (!expIf && arb.mc_mem_data !== 32'h11110000) begin
          failures++; $display("[TB] FAIL starve_memdata[%0d]: got %h want 11110000", n, arb.mc_mem_data);
        end
      end
    end
    arb.mem_mc_en = 1'b0;
    arb.if_mc_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_if_during_write();
    doReset();
    arb.mem_mc_addr = 16'h0060;
    arb.mem_mc_data = 32'hA5A50F0F;
    arb.mem_mc_rw = MC_RW_WRITE;
    arb.mem_mc_en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      checks++; if (arb.mc_ram_wre !== (j == 0)) begin failures++; $display("[TB] FAIL ifwr_wre[%0d]: got %b want %b", j, arb.mc_ram_wre, j == 0); end
      checks++; if (arb.mc_ram_oe !== (j == 3)) begin failures++; $display("[TB] FAIL ifwr_oe[%0d]: got %b want %b", j, arb.mc_ram_oe, j == 3); end
      checks++; if (arb.mc_mem_valid !== (j == 1)) begin failures++; $display("[TB] FAIL ifwr_memvalid[%0d]: got %b want %b", j, arb.mc_mem_valid, j == 1); end
      checks++; if (arb.mc_if_valid !== (j == 4)) begin failures++; $display("[TB] FAIL ifwr_ifvalid[%0d]: got %b want %b", j, arb.mc_if_valid, j == 4); end
      if (j == 0) begin
        arb.if_mc_addr = 16'h0060;
        arb.if_mc_en = 1'b1;
      end
      if (j == 1) arb.mem_mc_en = 1'b0;
      if (j == 4) begin
        checks++; if (arb.mc_if_data !== 32'hA5A50F0F) begin failures++; $display("[TB] FAIL ifwr_data: got %h want a5a50f0f", arb.mc_if_data); end
        arb.if_mc_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    doReset();
    preload(16'h0010, 32'hDEADBEEF);
    arb.mem_mc_addr = 16'h0030;
    arb.mem_mc_data = 32'hCAFEF00D;
    arb.mem_mc_rw = MC_RW_WRITE;
    arb.mem_mc_en = 1'b1;
    @(negedge clock);
    checks++; if (arb.mc_ram_wre !== 1'b1) begin failures++; $display("[TB] FAIL rstwr_in_wr: got wre=%b want 1", arb.mc_ram_wre); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({arb.mc_ram_wre, arb.mc_ram_oe} !== 2'b00) begin failures++; $display("[TB] FAIL rstwr_strobes: got wre=%b oe=%b want 00", arb.mc_ram_wre, arb.mc_ram_oe); end
    checks++; if ({arb.mc_if_valid, arb.mc_mem_valid} !== 2'b00) begin failures++; $display("[TB] FAIL rstwr_valid: got %b%b want 00", arb.mc_if_valid, arb.mc_mem_valid); end
    checks++; if (!busIdle()) begin failures++; $display("[TB] FAIL rstwr_bus: got %h want high-Z", ramBus); end
    reset = 1'b0;
    arb.mem_mc_en = 1'b0;
    @(negedge clock);
    checks++; if ({arb.mc_if_valid, arb.mc_mem_valid, arb.mc_ram_wre} !== 3'b000) begin failures++; $display("[TB] FAIL rstwr_after: got ifv=%b memv=%b wre=%b want 000", arb.mc_if_valid, arb.mc_mem_valid, arb.mc_ram_wre); end
    arb.if_mc_addr = 16'h0010;
    arb.if_mc_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      checks++; if (arb.mc_ram_oe !== (j == 0)) begin failures++; $display("[TB] FAIL rstwr_rd_oe[%0d]: got %b want %b", j, arb.mc_ram_oe, j == 0); end
      checks++; if (arb.mc_if_valid !== (j == 1)) begin failures++; $display("[TB] FAIL rstwr_rd_valid[%0d]: got %b want %b", j, arb.mc_if_valid, j == 1); end
      checks++; if (arb.mc_mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstwr_rd_memvalid[%0d]: got %b want 0", j, arb.mc_mem_valid); end
      if (j == 1) begin
        checks++; if (arb.mc_if_data !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rstwr_rd_data: got %h want deadbeef", arb.mc_if_data); end
        arb.if_mc_en = 1'b0;
      end
    end
  endtask

  // Transaction-level model: the arbiter accepts at the first edge it is free,
  // strobes the RAM for the following cycle, returns valid one cycle later and
  // is free again three edges after the grant.
  task automatic test_random();
    int e, freeAt, grantEdge, starve, issued, completed, dutValids;
    bit gMem, gWrite, ifPend, memPend, expOe, expWre, expIfV, expMemV, finished;
    logic [ADDR_W-1:0] gAddr;
    logic [DATA_W-1:0] gData, expIf, expMem;
    logic [DATA_W-1:0] modelRam [0:63];
    doReset();
    for (int i = 0; i < 64; i++) begin
      modelRam[i] = $urandom;
      preload(16'h0100 + 16'(i), modelRam[i]);
    end
    e = 0; freeAt = 1; grantEdge = -10; starve = 0;
    issued = 0; completed = 0; dutValids = 0; finished = 1'b0;
    gMem = 1'b0; gWrite = 1'b0; gAddr = '0; gData = '0;
    ifPend = 1'b0; memPend = 1'b0; expIf = '0; expMem = '0;
    for (int guard = 0; guard < 20000; guard++) begin
      expOe   = (e == grantEdge) && !gWrite;
      expWre  = (e == grantEdge) && gWrite;
      expIfV  = (e == grantEdge + 1) && !gMem;
      expMemV = (e == grantEdge + 1) && gMem;
      if (expIfV) begin expIf = gData; ifPend = 1'b0; completed++; end
      if (expMemV) begin
        if (!gWrite) expMem = gData;
        memPend = 1'b0;
        completed++;
      end
      dutValids += int'(arb.mc_if_valid) + int'(arb.mc_mem_valid);
      checks++; if (arb.mc_ram_oe !== expOe) begin failures++; $display("[TB] FAIL rnd_oe@%0d: got %b want %b", e, arb.mc_ram_oe, expOe); end
      checks++; if (arb.mc_ram_wre !== expWre) begin failures++; $display("[TB] FAIL rnd_wre@%0d: got %b want %b", e, arb.mc_ram_wre, expWre); end
      checks++; if (arb.mc_ram_wre && arb.mc_ram_oe) begin failures++; $display("[TB] FAIL rnd_wre_oe_excl@%0d: got both high want never", e); end
      checks++; if (arb.mc_if_valid !== expIfV) begin failures++; $display("[TB] FAIL rnd_ifvalid@%0d: got %b want %b", e, arb.mc_if_valid, expIfV); end
      checks++; if (arb.mc_mem_valid !== expMemV) begin failures++; $display("[TB] FAIL rnd_memvalid@%0d: got %b want %b", e, arb.mc_mem_valid, expMemV); end
      checks++; if (arb.mc_if_data !== expIf) begin failures++; $display("[TB] FAIL rnd_ifdata@%0d: got %h want %h", e, arb.mc_if_data, expIf); end
      checks++; if (arb.mc_mem_data !== expMem) begin failures++; $display("[TB] FAIL rnd_memdata@%0d: got %h want %h", e, arb.mc_mem_data, expMem); end
      checks++;
      if (expWre || expOe) begin
        if (ramBus !== gData) begin failures++; $display("[TB] FAIL rnd_bus@%0d: got %h want %h", e, ramBus, gData); end
      end else if (!busIdle()) begin
        failures++; $display("[TB] FAIL rnd_bus_idle@%0d: got %h want high-Z", e, ramBus);
      end
      if ((expWre || expOe) && arb.mc_ram_addr !== gAddr) begin
        failures++; $display("[TB] FAIL rnd_addr@%0d: got %h want %h", e, arb.mc_ram_addr, gAddr);
      end
      if (issued >= 1000 && completed == issued) begin finished = 1'b1; break; end
      if (failures > 40) break;
      if (!ifPend) begin
        arb.if_mc_en = 1'b0;
        if (issued < 1000 && $urandom_range(2) != 0) begin
          ifPend = 1'b1; issued++;
          arb.if_mc_en = 1'b1;
          arb.if_mc_addr = 16'h0100 + 16'($urandom_range(63));
        end
      end
      if (!memPend) begin
        arb.mem_mc_en = 1'b0;
        if (issued < 1000 && $urandom_range(2) != 0) begin
          memPend = 1'b1; issued++;
          arb.mem_mc_en = 1'b1;
          arb.mem_mc_rw = ($urandom_range(1) == 1) ? MC_RW_WRITE : MC_RW_READ;
          arb.mem_mc_addr = 16'h0100 + 16'($urandom_range(63));
          arb.mem_mc_data = $urandom;
        end
      end
      if (e + 1 >= freeAt) begin
        if (arb.mem_mc_en && (!arb.if_mc_en || starve < LIMIT)) begin
          gMem = 1'b1; gWrite = arb.mem_mc_rw; gAddr = arb.mem_mc_addr;
          starve = arb.if_mc_en ? starve + 1 : 0;
        end else if (arb.if_mc_en) begin
          gMem = 1'b0; gWrite = 1'b0; gAddr = arb.if_mc_addr;
          starve = 0;
        end else begin
          starve = 0;
        end
        if (arb.mem_mc_en || arb.if_mc_en) begin
          grantEdge = e + 1;
          freeAt = e + 4;
          if (gWrite) begin
            gData = arb.mem_mc_data;
            modelRam[int'(gAddr) - 256] = gData;
          end else begin
            gData = modelRam[int'(gAddr) - 256];
          end
        end
      end
      @(negedge clock);
      e++;
    end
    arb.if_mc_en = 1'b0;
    arb.mem_mc_en = 1'b0;
    checks++; if (!finished) begin failures++; $display("[TB] FAIL rnd_complete: got %0d of %0d completions want all", completed, issued); end
    checks++; if (dutValids != issued) begin failures++; $display("[TB] FAIL rnd_valid_count: got %0d valids want %0d", dutValids, issued); end
  endtask

  initial begin
    reset = 1'b1;
    preloadEn = 1'b0;
    preloadAddr = '0;
    preloadData = '0;
    test_reset();
    test_if_read();
    test_mem_write_read();
    test_starvation();
    test_if_during_write();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of run within 2 ms want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
